// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
//   - FSM state encoding (IDLE/ISSUE/WAIT/RESP)
//   - register-file address/data widths
//   - requester identifiers (core, debug)
//   - packed bundle of one access request's fields
package regfile_port_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_DBG  = 1'b1
   } req_id_e;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] ra1;
      logic [REG_ADDR_W-1:0] ra2;
      logic [REG_ADDR_W-1:0] wa;
      logic [REG_DATA_W-1:0] wd;
   } rf_req_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Winner select for the register-file port, with debug anti-starvation.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   c_req_i    : core request level
//   d_req_i    : debug request level
//   grant_i    : a grant is being taken this cycle (arbiter in IDLE with a request)
//   win_o      : requester that wins if a grant is taken this cycle
module regfile_rr_pick
   import regfile_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    c_req_i,
   input  logic    d_req_i,
   input  logic    grant_i,
   output req_id_e win_o
);

   localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q, starve_d;

   // Core is the default winner; debug takes the port when it is alone or
   // when it has watched LIMIT consecutive core grants go by.
   always_comb begin
      win_o = REQ_CORE;
      if (d_req_i && (!c_req_i || (starve_q == LIMIT))) begin
         win_o = REQ_DBG;
      end
   end

   // The count only measures starvation while debug is actually waiting,
   // so it drops to zero whenever debug stops requesting. It saturates.
   always_comb begin
      starve_d = starve_q;
      if (!d_req_i) begin
         starve_d = '0;
      end else if (grant_i) begin
         if (win_o == REQ_DBG) begin
            starve_d = '0;
         end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single register-file access port between the core control FSM
// (requester 0) and the debug/readout path (requester 1). Each access is one
// rf_en cycle, a wait for rf_done, and a one-cycle ack carrying the read data.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   c_req/c_we/c_ra1/c_ra2/c_wa/c_wd : core request and its access fields
//   d_req/d_we/d_ra1/d_ra2/d_wa/d_wd : debug request and its access fields
//   c_ack, d_ack                   : one-cycle completion pulse per requester
//   rd1, rd2                       : read data of the acked access, held until next ack
//   rf_en/rf_we/rf_ra1/rf_ra2/rf_wa/rf_wd : drive to RegisterFile
//   rf_rd1, rf_rd2, rf_done        : from RegisterFile
//   err                            : sticky access-timeout flag, cleared only by rst
module regfile_port_arbiter
   import regfile_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT      = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [REG_ADDR_W-1:0] c_ra1,
   input  logic [REG_ADDR_W-1:0] c_ra2,
   input  logic [REG_ADDR_W-1:0] c_wa,
   input  logic [REG_DATA_W-1:0] c_wd,
   output logic                  c_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [REG_ADDR_W-1:0] d_ra1,
   input  logic [REG_ADDR_W-1:0] d_ra2,
   input  logic [REG_ADDR_W-1:0] d_wa,
   input  logic [REG_DATA_W-1:0] d_wd,
   output logic                  d_ack,
   output logic [REG_DATA_W-1:0] rd1,
   output logic [REG_DATA_W-1:0] rd2,
   output logic                  rf_en,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_ra1,
   output logic [REG_ADDR_W-1:0] rf_ra2,
   output logic [REG_ADDR_W-1:0] rf_wa,
   output logic [REG_DATA_W-1:0] rf_wd,
   input  logic [REG_DATA_W-1:0] rf_rd1,
   input  logic [REG_DATA_W-1:0] rf_rd2,
   input  logic                  rf_done,
   output logic                  err
);

   // Last WAIT count before giving up: WAIT lasts TIMEOUT cycles at most.
   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

   state_e                state_q;
   req_id_e               owner_q;
   rf_req_t               fld_q;
   logic                  rf_en_q;
   logic                  c_ack_q, d_ack_q;
   logic [REG_DATA_W-1:0] rd1_q, rd2_q;
   logic                  err_q;
   logic [3:0]            tmo_q;

   rf_req_t c_fld, d_fld;
   req_id_e win;
   logic    grant;

   assign c_fld = {c_we, c_ra1, c_ra2, c_wa, c_wd};
   assign d_fld = {d_we, d_ra1, d_ra2, d_wa, d_wd};
   assign grant = (state_q == ST_IDLE) && (c_req || d_req);

   regfile_rr_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk    (clk),
      .rst    (rst),
      .c_req_i(c_req),
      .d_req_i(d_req),
      .grant_i(grant),
      .win_o  (win)
   );

   // Acks and rf_en are single-cycle strobes: they default low every cycle
   // and are raised only on the transition into RESP / ISSUE respectively.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= REQ_CORE;
         fld_q   <= '0;
         rf_en_q <= 1'b0;
         c_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         rf_en_q <= 1'b0;
         c_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  // Fields are frozen here so requester changes after grant
                  // cannot disturb the access in flight.
                  owner_q <= win;
                  fld_q   <= (win == REQ_DBG) ? d_fld : c_fld;
                  rf_en_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tmo_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (rf_done) begin
                  rd1_q   <= rf_rd1;
                  rd2_q   <= rf_rd2;
                  c_ack_q <= (owner_q == REQ_CORE);
                  d_ack_q <= (owner_q == REQ_DBG);
                  state_q <= ST_RESP;
               end else if (tmo_q == TMO_LAST) begin
                  // Abandon the access but still release the owner.
                  rd1_q   <= '0;
                  rd2_q   <= '0;
                  err_q   <= 1'b1;
                  c_ack_q <= (owner_q == REQ_CORE);
                  d_ack_q <= (owner_q == REQ_DBG);
                  state_q <= ST_RESP;
               end else begin
                  tmo_q <= tmo_q + 4'd1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign c_ack  = c_ack_q;
   assign d_ack  = d_ack_q;
   assign rd1    = rd1_q;
   assign rd2    = rd2_q;
   assign err    = err_q;
   assign rf_en  = rf_en_q;
   assign rf_we  = fld_q.we;
   assign rf_ra1 = fld_q.ra1;
   assign rf_ra2 = fld_q.ra2;
   assign rf_wa  = fld_q.wa;
   assign rf_wd  = fld_q.wd;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_req = 1'b0, c_we = 1'b0;
   logic [4:0]  c_ra1 = '0, c_ra2 = '0, c_wa = '0;
   logic [31:0] c_wd = '0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [4:0]  d_ra1 = '0, d_ra2 = '0, d_wa = '0;
   logic [31:0] d_wd = '0;
   logic        c_ack, d_ack, rf_en, rf_we, err;
   logic [31:0] rd1, rd2, rf_wd;
   logic [4:0]  rf_ra1, rf_ra2, rf_wa;
   logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
   logic        rf_done = 1'b0;

   regfile_port_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_ra1(c_ra1), .c_ra2(c_ra2), .c_wa(c_wa), .c_wd(c_wd),
      .c_ack(c_ack),
      .d_req(d_req), .d_we(d_we), .d_ra1(d_ra1), .d_ra2(d_ra2), .d_wa(d_wa), .d_wd(d_wd),
      .d_ack(d_ack),
      .rd1(rd1), .rd2(rd2),
      .rf_en(rf_en), .rf_we(rf_we), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_done(rf_done),
      .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int req_cyc = 0;
   int dual_ack = 0;
   bit rf_hang = 1'b0;
   logic [31:0] ref_regs [32] = '{default: '0};
   logic [31:0] mem [32] = '{default: '0};

   logic [127:0] outvec;
   assign outvec = {12'd0, c_ack, d_ack, rd1, rd2, rf_en, rf_we, rf_ra1, rf_ra2, rf_wa, rf_wd, err};

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (c_ack && d_ack) dual_ack++;

   // Register file environment: answers one cycle after rf_en, read-before-write.
   always @(posedge clk) begin
      rf_done <= 1'b0;
      if (rf_en && !rf_hang) begin
         rf_done <= 1'b1;
         rf_rd1  <= mem[rf_ra1];
         rf_rd2  <= mem[rf_ra2];
         if (rf_we && rf_wa != 5'd0) mem[rf_wa] <= rf_wd;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req_on(input bit who, input bit we, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [4:0] wa, input logic [31:0] wd);
      if (!who) begin
         c_we = we; c_ra1 = ra1; c_ra2 = ra2; c_wa = wa; c_wd = wd; c_req = 1'b1;
      end else begin
         d_we = we; d_ra1 = ra1; d_ra2 = ra2; d_wa = wa; d_wd = wd; d_req = 1'b1;
      end
      req_cyc = cyc;
   endtask

   task automatic wait_ack(input string tag, input bit who, input int exp_lat,
                           input logic [31:0] e1, input logic [31:0] e2);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (c_ack || d_ack) got = 1'b1;
      end
      if (!got) begin
         chk({tag, "_noack"}, 128'd0, 128'd1);
      end else begin
         chk({tag, "_who"}, 128'({c_ack, d_ack}), who ? 128'd1 : 128'd2);
         chk({tag, "_lat"}, 128'(cyc - req_cyc), 128'(exp_lat));
         chk({tag, "_rd1"}, 128'(rd1), 128'(e1));
         chk({tag, "_rd2"}, 128'(rd2), 128'(e2));
      end
      if (!who) c_req = 1'b0; else d_req = 1'b0;
      @(negedge clk);
      chk({tag, "_pulse"}, 128'({c_ack, d_ack}), 128'd0);
   endtask

   task automatic access(input string tag, input bit who, input bit we, input logic [4:0] ra1,
                         input logic [4:0] ra2, input logic [4:0] wa, input logic [31:0] wd);
      logic [31:0] e1, e2;
      e1 = ref_regs[ra1];
      e2 = ref_regs[ra2];
      req_on(who, we, ra1, ra2, wa, wd);
      wait_ack(tag, who, 3, e1, e2);
      if (we && wa != 5'd0) ref_regs[wa] = wd;
   endtask

   initial begin
      int scnt, acks, last, n, quiet;
      bit exp_dbg;

      repeat (3) @(negedge clk);
      chk("rst_outs", outvec, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // T1: write then read back
      access("t1_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
      access("t1_rd", 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
      chk("t1_val", 128'(rd1), 128'(32'hDEADBEEF));

      // T2: r0 write is ignored by the register file
      access("t2_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
      access("t2_rd", 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);

      // T6: field change after grant
      access("t6_w3", 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'hA5A50003);
      access("t6_w7", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h77777777);
      req_on(1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
      repeat (2) @(negedge clk);
      c_ra1 = 5'd7;
      wait_ack("t6_rd", 1'b0, 3, ref_regs[3], ref_regs[7]);

      // Randomized single-requester traffic
      for (int i = 0; i < 40; i++) begin
         access("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), $urandom);
      end

      // T3: continuous contention, random reads
      req_on(1'b1, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 32'h0);
      req_on(1'b0, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 32'h0);
      scnt = 0; acks = 0; last = cyc; n = 0;
      while (acks < 27 && n < 200) begin
         @(negedge clk);
         n++;
         if (c_ack || d_ack) begin
            exp_dbg = (scnt == 8);
            chk("t3_who", 128'({c_ack, d_ack}), exp_dbg ? 128'd1 : 128'd2);
            if (exp_dbg) scnt = 0; else if (scnt < 8) scnt++;
            chk("t3_gap", 128'(cyc - last), (acks == 0) ? 128'd3 : 128'd4);
            last = cyc;
            if (d_ack) begin
               chk("t3_drd1", 128'(rd1), 128'(ref_regs[d_ra1]));
               chk("t3_drd2", 128'(rd2), 128'(ref_regs[d_ra2]));
               d_ra1 = 5'($urandom_range(0, 31)); d_ra2 = 5'($urandom_range(0, 31));
            end else begin
               chk("t3_crd1", 128'(rd1), 128'(ref_regs[c_ra1]));
               chk("t3_crd2", 128'(rd2), 128'(ref_regs[c_ra2]));
               c_ra1 = 5'($urandom_range(0, 31)); c_ra2 = 5'($urandom_range(0, 31));
            end
            acks++;
         end
      end
      if (acks < 27) chk("t3_noack", 128'd0, 128'd1);
      c_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
      chk("t3_dual", 128'(dual_ack), 128'd0);

      // T4: register file never answers
      rf_hang = 1'b1;
      req_on(1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
      wait_ack("t4", 1'b0, 17, 32'h0, 32'h0);
      chk("t4_err", 128'(err), 128'd1);
      rf_hang = 1'b0;
      access("t4_after", 1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
      chk("t4_sticky", 128'(err), 128'd1);

      // T5: reset in the WAIT cycle drops the access
      req_on(1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      c_req = 1'b0;
      @(negedge clk);
      chk("t5_outs", outvec, 128'd0);
      rst = 1'b0;
      quiet = 0;
      repeat (6) begin
         @(negedge clk);
         if (c_ack || d_ack || rf_en) quiet++;
      end
      chk("t5_quiet", 128'(quiet), 128'd0);
      access("t5_fresh", 1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
      chk("t5_err", 128'(err), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
